// File: rtl/seq_det_pkg.sv
// Shared constants and width helpers for the time-shared serial pattern detector.
package seq_det_pkg;
  localparam int NCH_DEF = 4;
  localparam int PMAX_DEF = 8;
  localparam int CW_DEF = 8;
  localparam int DEF_LEN = 6;
  localparam logic [5:0] DEF_PATTERN = 6'b101010;

  // Index width that stays at least 1 bit wide for tiny counts.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches req from the pointer upward, wraps, grants one requester.
module rr_arbiter
  import seq_det_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic [IW-1:0] ptr
);
  logic          found;
  logic [IW:0]   j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = '0;
    for (int i = 0; i < N; i++) begin
      j = {1'b0, ptr} + (IW+1)'(i);
      if (j >= (IW+1)'(N)) j = j - (IW+1)'(N);
      if (en && !found && req[j[IW-1:0]]) begin
        found   = 1'b1;
        gnt[j[IW-1:0]] = 1'b1;
        gnt_idx = j[IW-1:0];
      end
    end
  end

  // Pointer moves past the winner only when something was actually granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + IW'(1);
    end
  end
endmodule

// File: rtl/seq_detect_sched.sv
// Programmable serial-pattern detector shared by NCH bit-serial channels through
// one compare engine; per-channel history, fill level and saturating match counts.
module seq_detect_sched
  import seq_det_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int PMAX = PMAX_DEF,
  parameter int CW = CW_DEF,
  localparam int CHW = idx_w(NCH),
  localparam int LW = idx_w(PMAX+1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_we,
  input  logic [PMAX-1:0] cfg_pattern,
  input  logic [LW-1:0]   cfg_len,
  input  logic            cfg_overlap,
  output logic            cfg_err,
  input  logic [NCH-1:0]  in_valid,
  input  logic [NCH-1:0]  in_bit,
  output logic [NCH-1:0]  in_ready,
  output logic            match_valid,
  output logic [CHW-1:0]  match_ch,
  input  logic [CHW-1:0]  cnt_sel,
  output logic [CW-1:0]   cnt_out
);
  // Handshake: channel i transfers in_bit[i] on a rising edge where in_valid[i] and
  // in_ready[i] are both high; in_ready is one-hot (or zero) and never waits on a transfer.

  logic [PMAX-1:0] pattern;
  logic [LW-1:0]   len;
  logic            overlap;
  logic [PMAX-1:0] hist [NCH];
  logic [LW-1:0]   fill [NCH];
  logic [CW-1:0]   cnt  [NCH];

  logic [NCH-1:0]  gnt;
  logic [CHW-1:0]  gnt_idx;
  logic [CHW-1:0]  rr_ptr;
  logic            xfer;
  logic            cfg_legal;
  logic [PMAX-1:0] hist_cur;
  logic [PMAX-1:0] new_hist;
  logic [LW-1:0]   new_fill;
  logic [PMAX-1:0] len_mask;
  logic            hit;

  rr_arbiter #(.N(NCH)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (in_valid),
    .en      (!cfg_we),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .ptr     (rr_ptr)
  );

  assign in_ready  = gnt;
  assign xfer      = |gnt;
  assign cfg_legal = (cfg_len != '0) && (cfg_len <= LW'(PMAX));

  // Single shared compare engine operating on the granted channel only.
  always_comb begin
    hist_cur = hist[gnt_idx];
    new_hist = (hist_cur << 1) | PMAX'(in_bit[gnt_idx]);
    new_fill = (fill[gnt_idx] >= len) ? len : fill[gnt_idx] + LW'(1);
    len_mask = {PMAX{1'b1}} >> (LW'(PMAX) - len);
    hit      = xfer && (new_fill == len) && (((new_hist ^ pattern) & len_mask) == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern     <= PMAX'(DEF_PATTERN);
      len         <= LW'(DEF_LEN);
      overlap     <= 1'b1;
      match_valid <= 1'b0;
      match_ch    <= '0;
      cfg_err     <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        hist[i] <= '0;
        fill[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      match_valid <= hit;
      cfg_err     <= cfg_we && !cfg_legal;
      if (hit) match_ch <= gnt_idx;
      if (cfg_we) begin
        if (cfg_legal) begin
          pattern <= cfg_pattern;
          len     <= cfg_len;
          overlap <= cfg_overlap;
          for (int i = 0; i < NCH; i++) begin
            hist[i] <= '0;
            fill[i] <= '0;
            cnt[i]  <= '0;
          end
        end
      end else if (xfer) begin
        hist[gnt_idx] <= new_hist;
        fill[gnt_idx] <= (hit && !overlap) ? '0 : new_fill;
        if (hit && (cnt[gnt_idx] != '1)) cnt[gnt_idx] <= cnt[gnt_idx] + CW'(1);
      end
    end
  end

  generate
    if (NCH == (1 << CHW)) begin : g_cnt_full
      assign cnt_out = cnt[cnt_sel];
    end else begin : g_cnt_guard
      assign cnt_out = (cnt_sel < CHW'(NCH)) ? cnt[cnt_sel] : '0;
    end
  endgenerate
endmodule

// File: tb/tb_seq_detect_sched.sv
// Bench for seq_detect_sched: directed scenarios plus random traffic against a
// queue-based reference model; match events are scoreboarded through exp_q.
module tb_seq_detect_sched;
  localparam int NCH = 4;
  localparam int PMAX = 8;
  localparam int CW = 2;
  localparam int CHW = 2;
  localparam int LW = 4;
  localparam int W = 20;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cfg_we = 1'b0;
  logic [PMAX-1:0] cfg_pattern = '0;
  logic [LW-1:0]   cfg_len = '0;
  logic            cfg_overlap = 1'b0;
  logic            cfg_err;
  logic [NCH-1:0]  in_valid = '0;
  logic [NCH-1:0]  in_bit = '0;
  logic [NCH-1:0]  in_ready;
  logic            match_valid;
  logic [CHW-1:0]  match_ch;
  logic [CHW-1:0]  cnt_sel = '0;
  logic [CW-1:0]   cnt_out;

  always #5 clk = ~clk;

  seq_detect_sched #(.NCH(NCH), .PMAX(PMAX), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .match_valid(match_valid), .match_ch(match_ch), .cnt_sel(cnt_sel), .cnt_out(cnt_out)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];
  logic exp_cfg_err = 1'b0;

  // Reference model: per-channel queue of the most recent bits, oldest first.
  logic [PMAX-1:0] m_pat;
  int m_len;
  bit m_ovl;
  int m_ptr;
  int m_cnt[NCH];
  int m_hist[NCH][$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_pat = 8'b0010_1010;
    m_len = 6;
    m_ovl = 1'b1;
    m_ptr = 0;
    exp_cfg_err = 1'b0;
    exp_q.delete();
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c] = 0;
      m_hist[c].delete();
    end
  endfunction

  function automatic int model_grant(input logic [NCH-1:0] v, input logic we);
    if (we) return -1;
    for (int k = 0; k < NCH; k++)
      if (v[(m_ptr + k) % NCH]) return (m_ptr + k) % NCH;
    return -1;
  endfunction

  function automatic void model_step(input int g, input logic [NCH-1:0] b, input logic we,
                                     input logic [PMAX-1:0] pat, input logic [LW-1:0] len,
                                     input logic ovl);
    bit hit;
    exp_cfg_err = 1'b0;
    if (we) begin
      if (len >= 1 && len <= PMAX) begin
        m_pat = pat;
        m_len = int'(len);
        m_ovl = ovl;
        for (int c = 0; c < NCH; c++) begin
          m_cnt[c] = 0;
          m_hist[c].delete();
        end
      end else begin
        exp_cfg_err = 1'b1;
      end
    end else if (g >= 0) begin
      m_hist[g].push_back(int'(b[g]));
      if (m_hist[g].size() > m_len) void'(m_hist[g].pop_front());
      hit = (m_hist[g].size() == m_len);
      for (int k = 0; k < m_len && hit; k++)
        if (m_hist[g][k] != int'(m_pat[m_len-1-k])) hit = 1'b0;
      if (hit) begin
        exp_q.push_back({cyc[15:0], 4'(g)});
        if (m_cnt[g] < (1 << CW) - 1) m_cnt[g]++;
        if (!m_ovl) m_hist[g].delete();
      end
      m_ptr = (g + 1) % NCH;
    end
  endfunction

  task automatic drive(input logic [NCH-1:0] v, input logic [NCH-1:0] b, input logic we,
                       input logic [PMAX-1:0] pat, input logic [LW-1:0] len, input logic ovl);
    int g;
    @(negedge clk);
    in_valid = v;
    in_bit = b;
    cfg_we = we;
    cfg_pattern = pat;
    cfg_len = len;
    cfg_overlap = ovl;
    cnt_sel = CHW'($urandom_range(0, NCH-1));
    #1;
    g = model_grant(v, we);
    chk("in_ready", 32'(in_ready), (g < 0) ? 0 : (1 << g));
    chk("cnt_out", 32'(cnt_out), m_cnt[cnt_sel]);
    @(posedge clk);
    cyc++;
    model_step(g, b, we, pat, len, ovl);
  endtask

  task automatic send(input logic [NCH-1:0] v, input logic [NCH-1:0] b);
    drive(v, b, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic cfg(input logic [PMAX-1:0] pat, input logic [LW-1:0] len, input logic ovl,
                     input logic [NCH-1:0] v);
    drive(v, '0, 1'b1, pat, len, ovl);
  endtask

  task automatic send_bits(input int ch, input logic [15:0] bits, input int n);
    for (int k = n - 1; k >= 0; k--) send(NCH'(1 << ch), NCH'(bits[k]) << ch);
  endtask

  task automatic check_cnt(input int ch, input int exp);
    @(negedge clk);
    in_valid = '0;
    cfg_we = 1'b0;
    cnt_sel = CHW'(ch);
    #1;
    chk("cnt_const", 32'(cnt_out), exp);
    @(posedge clk);
    cyc++;
    model_step(-1, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_match_valid", 32'(match_valid), 0);
    chk("reset_cfg_err", 32'(cfg_err), 0);
    in_valid = '0;
    cfg_we = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compares match events and cfg_err against the model's expectations.
  always @(negedge clk) begin : monitor
    logic expv;
    logic [W-1:0] e;
    if (rst_n) begin
      chk("cfg_err", 32'(cfg_err), 32'(exp_cfg_err));
      expv = 1'b0;
      e = '0;
      if (exp_q.size() > 0 && exp_q[0][19:4] == cyc[15:0]) begin
        expv = 1'b1;
        e = exp_q.pop_front();
      end
      chk("match_valid", 32'(match_valid), 32'(expv));
      if (expv && match_valid) chk("match_ch", 32'(match_ch), 32'(e[3:0]));
    end
  end

  initial begin : stim
    int pos[NCH];
    logic [5:0] s6;
    logic [NCH-1:0] b;
    int g;
    s6 = 6'b101010;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_match_valid", 32'(match_valid), 0);
    chk("rst_cfg_err", 32'(cfg_err), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    for (int c = 0; c < NCH; c++) check_cnt(c, 0);

    // Default pattern with overlap on channel 0.
    send_bits(0, 16'b1010_1010, 8);
    check_cnt(0, 2);

    // Non-overlapping mode.
    cfg(8'b0010_1010, 4'd6, 1'b0, '0);
    send_bits(0, 16'b1010_1010, 8);
    check_cnt(0, 1);

    // Four channels streaming concurrently; grants rotate.
    cfg(8'b0010_1010, 4'd6, 1'b1, '0);
    for (int c = 0; c < NCH; c++) pos[c] = 0;
    for (int t = 0; t < 24; t++) begin
      b = '0;
      for (int c = 0; c < NCH; c++) if (pos[c] < 6) b[c] = s6[5 - pos[c]];
      g = model_grant('1, 1'b0);
      send('1, b);
      if (g >= 0) pos[g]++;
    end
    for (int c = 0; c < NCH; c++) check_cnt(c, 1);

    // Reconfiguration under load blocks transfers and clears counters.
    cfg(8'b1111_1110, 4'd3, 1'b1, '1);
    for (int c = 0; c < NCH; c++) check_cnt(c, 0);
    send_bits(2, 16'b110, 3);
    check_cnt(2, 1);

    // Illegal lengths are rejected; detection keeps working.
    cfg(8'b0010_1010, 4'd6, 1'b1, '0);
    cfg(8'b1111_1111, 4'd0, 1'b0, '0);
    cfg(8'b1111_1111, 4'd9, 1'b0, '0);
    send_bits(1, 16'b10_1010, 6);
    check_cnt(1, 1);

    // Saturation, then reset in the middle of traffic.
    send_bits(0, 16'b1010, 4);
    send_bits(1, 16'b1010_1010, 8);
    check_cnt(1, 3);
    send_bits(1, 16'b10, 2);
    reset_mid();
    send_bits(0, 16'b10, 2);
    check_cnt(0, 0);

    // Random traffic.
    for (int t = 0; t < 1500; t++) begin
      if ($urandom_range(0, 99) < 3) begin
        cfg(PMAX'($urandom), LW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : $urandom_range(1, 4)),
            1'($urandom), NCH'($urandom));
      end else if ($urandom_range(0, 999) < 3) begin
        reset_mid();
      end else begin
        send(NCH'($urandom), NCH'($urandom));
      end
    end

    send('0, '0);
    send('0, '0);
    chk("exp_q_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
